// File: rtl/memoria_instrucao_carregavel_if.sv
// Loader, fetch and status signals of the loadable instruction memory.
// master = the party that loads the program and issues fetches; slave = the memory.
// Handshake: a loader word is taken on every edge where carga_valido=1 while
// carga_pronto=1. A fetch is taken on an edge where busca_req=1 and pronto=1.
// Its result appears for exactly one cycle, one edge later, with busca_valido=1.
// There is no back-pressure on results, so a new request may be issued every cycle.
interface memoria_instrucao_carregavel_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              carga_valido;
  logic [DATA_W-1:0] carga_dado;
  logic              carga_fim;
  logic              carga_pronto;
  logic              recarga;
  logic              busca_req;
  logic [ADDR_W-1:0] Endereco;
  logic [DATA_W-1:0] Instrucao;
  logic              busca_valido;
  logic              erro_endereco;
  logic              pronto;
  logic              estouro;
  logic              estado_dbg;

  modport master (
    output carga_valido, carga_dado, carga_fim, recarga, busca_req, Endereco,
    input  carga_pronto, Instrucao, busca_valido, erro_endereco, pronto, estouro,
           estado_dbg
  );

  modport slave (
    input  carga_valido, carga_dado, carga_fim, recarga, busca_req, Endereco,
    output carga_pronto, Instrucao, busca_valido, erro_endereco, pronto, estouro,
           estado_dbg
  );
endinterface

// File: rtl/memoria_instrucao_carregavel.sv
// Loadable instruction memory: a sequential loader fills words from address 0,
// and the fetch port then serves registered reads. Unloaded or out-of-range words read as NOP.
module memoria_instrucao_carregavel #(
  parameter int              DATA_W    = 32,
  parameter int              DEPTH     = 64,
  parameter int              ADDR_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(32'h8000_0000)
) (
  input  logic                          clock,
  input  logic                          reset,
  memoria_instrucao_carregavel_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CMP_W = (ADDR_W > CNT_W) ? ADDR_W : CNT_W;

  typedef enum logic {
    CARGA  = 1'b0,
    PRONTO = 1'b1
  } estado_t;

  estado_t           estado_q, estado_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              estouro_q, estouro_d;
  logic              valido_q, valido_d;
  logic              erro_q, erro_d;
  logic [DATA_W-1:0] instr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              wr_en;
  logic              rd_hit;
  logic              rd_miss;
  logic              busca_acerto;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;

  // The whole PC is compared, so high address bits cannot alias onto loaded words.
  assign busca_acerto = CMP_W'(bus.Endereco) < CMP_W'(count_q);
  assign wr_idx       = count_q[IDX_W-1:0];
  assign rd_idx       = bus.Endereco[IDX_W-1:0];

  always_comb begin
    estado_d  = estado_q;
    count_d   = count_q;
    estouro_d = estouro_q;
    valido_d  = 1'b0;
    erro_d    = 1'b0;
    wr_en     = 1'b0;
    rd_hit    = 1'b0;
    rd_miss   = 1'b0;
    case (estado_q)
      CARGA: begin
        // A word that arrives together with carga_fim is still written.
        if (bus.carga_valido) begin
          if (count_q < CNT_W'(DEPTH)) begin
            wr_en   = 1'b1;
            count_d = count_q + CNT_W'(1);
          end else begin
            estouro_d = 1'b1;
          end
        end
        if (bus.carga_fim) begin
          estado_d = PRONTO;
        end
      end
      PRONTO: begin
        // recarga wins over a fetch in the same cycle; that fetch is dropped.
        if (bus.recarga) begin
          estado_d  = CARGA;
          count_d   = '0;
          estouro_d = 1'b0;
        end else if (bus.busca_req) begin
          valido_d = 1'b1;
          if (busca_acerto) begin
            rd_hit = 1'b1;
          end else begin
            rd_miss = 1'b1;
            erro_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q  <= CARGA;
      count_q   <= '0;
      estouro_q <= 1'b0;
      valido_q  <= 1'b0;
      erro_q    <= 1'b0;
      instr_q   <= NOP_INSTR;
    end else begin
      estado_q  <= estado_d;
      count_q   <= count_d;
      estouro_q <= estouro_d;
      valido_q  <= valido_d;
      erro_q    <= erro_d;
      // Instrucao keeps its last value on cycles without a fetch.
      if (rd_hit) begin
        instr_q <= mem_q[rd_idx];
      end else if (rd_miss) begin
        instr_q <= NOP_INSTR;
      end
    end
  end

  // Program storage is not reset; the fill count alone decides which words are valid.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_idx] <= bus.carga_dado;
    end
  end

  assign bus.Instrucao     = instr_q;
  assign bus.busca_valido  = valido_q;
  assign bus.erro_endereco = erro_q;
  assign bus.estouro       = estouro_q;
  assign bus.pronto        = (estado_q == PRONTO);
  assign bus.carga_pronto  = (estado_q == CARGA);
  assign bus.estado_dbg    = estado_q;
endmodule

// File: tb/tb_memoria_instrucao_carregavel.sv
// Directed bench for the loadable instruction memory: the stimulus pushes expected
// fetch results, and a monitor pops and compares them whenever busca_valido is high.
module tb_memoria_instrucao_carregavel;
  localparam logic [31:0] NOP = 32'h8000_0000;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;
  logic [32:0] exp_q[$];
  logic [32:0] exp_e;
  logic [31:0] prog [11];

  memoria_instrucao_carregavel_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  memoria_instrucao_carregavel #(
    .DATA_W(32), .DEPTH(64), .ADDR_W(32), .NOP_INSTR(32'h8000_0000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Clock and reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1);
  end

  // Driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.carga_valido = 1'b0;
    bus.carga_dado   = '0;
    bus.carga_fim    = 1'b0;
    bus.recarga      = 1'b0;
    bus.busca_req    = 1'b0;
    bus.Endereco     = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] data, input logic fim);
    bus.carga_valido = 1'b1;
    bus.carga_dado   = data;
    bus.carga_fim    = fim;
    step();
    bus.carga_valido = 1'b0;
    bus.carga_fim    = 1'b0;
  endtask

  task automatic load_end();
    bus.carga_fim = 1'b1;
    step();
    bus.carga_fim = 1'b0;
  endtask

  // Leaves busca_req asserted so that consecutive calls issue back-to-back requests.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_instr, input logic exp_err);
    bus.busca_req = 1'b1;
    bus.Endereco  = addr;
    exp_q.push_back({exp_err, exp_instr});
    step();
    check("fetch_latency_valid", {31'd0, bus.busca_valido}, 32'd1);
  endtask

  task automatic fetch_ignored(input logic [31:0] addr);
    bus.busca_req = 1'b1;
    bus.Endereco  = addr;
    step();
    bus.busca_req = 1'b0;
    check("ignored_fetch_valid", {31'd0, bus.busca_valido}, 32'd0);
    check("ignored_fetch_erro", {31'd0, bus.erro_endereco}, 32'd0);
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    if (!reset && bus.busca_valido) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_valid: got busca_valido=1 Instrucao=%h expected no result",
                 bus.Instrucao);
      end else begin
        exp_e = exp_q.pop_front();
        check("mon_instrucao", bus.Instrucao, exp_e[31:0]);
        check("mon_erro_endereco", {31'd0, bus.erro_endereco}, {31'd0, exp_e[32]});
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    prog[0]  = 32'h2401_0000;  // li   $1,0
    prog[1]  = 32'h2402_0005;  // li   $2,5
    prog[2]  = 32'h1022_0004;  // beq  $1,$2,+4
    prog[3]  = 32'h2421_0001;  // addiu $1,$1,1
    prog[4]  = 32'h0800_0002;  // j    2
    prog[5]  = 32'hAC01_0000;  // sw
    prog[6]  = 32'h8C03_0000;  // lw
    prog[7]  = 32'h0022_1820;  // add
    prog[8]  = 32'h0022_2022;  // sub
    prog[9]  = 32'h0022_2825;  // or
    prog[10] = 32'h0000_0000;  // nop

    // 1: reset state, fetch ignored while loading
    do_reset();
    check("rst_instrucao", bus.Instrucao, NOP);
    check("rst_pronto", {31'd0, bus.pronto}, 32'd0);
    check("rst_carga_pronto", {31'd0, bus.carga_pronto}, 32'd1);
    check("rst_estouro", {31'd0, bus.estouro}, 32'd0);
    check("rst_valido", {31'd0, bus.busca_valido}, 32'd0);
    fetch_ignored(32'd0);
    check("t1_pronto", {31'd0, bus.pronto}, 32'd0);
    check("t1_carga_pronto", {31'd0, bus.carga_pronto}, 32'd1);

    // 2: load 11 words, carga_fim on the last, then fetch address 2
    for (int i = 0; i < 11; i++) begin
      load_word(prog[i], (i == 10));
    end
    check("t2_pronto", {31'd0, bus.pronto}, 32'd1);
    check("t2_carga_pronto", {31'd0, bus.carga_pronto}, 32'd0);
    fetch(32'd2, 32'h1022_0004, 1'b0);
    idle();
    step();
    check("t2_idle_valido", {31'd0, bus.busca_valido}, 32'd0);
    check("t2_idle_erro", {31'd0, bus.erro_endereco}, 32'd0);
    check("t2_instr_hold", bus.Instrucao, 32'h1022_0004);

    // 3: out-of-range fetches, then back-to-back fetches
    fetch(32'd11, NOP, 1'b1);
    fetch(32'hFFFF_0002, NOP, 1'b1);
    fetch(32'd0, 32'h2401_0000, 1'b0);
    fetch(32'd1, 32'h2402_0005, 1'b0);
    fetch(32'd2, 32'h1022_0004, 1'b0);
    idle();
    step();

    // 4: overflow the 64-word memory
    do_reset();
    for (int i = 0; i < 66; i++) begin
      load_word(32'hA500_0000 | i, 1'b0);
    end
    check("t4_estouro", {31'd0, bus.estouro}, 32'd1);
    check("t4_still_carga", {31'd0, bus.carga_pronto}, 32'd1);
    load_end();
    check("t4_pronto", {31'd0, bus.pronto}, 32'd1);
    fetch(32'd63, 32'hA500_003F, 1'b0);
    fetch(32'd64, NOP, 1'b1);
    fetch(32'd0, 32'hA500_0000, 1'b0);
    idle();
    step();

    // 5: recarga beats a same-cycle fetch
    bus.recarga   = 1'b1;
    bus.busca_req = 1'b1;
    bus.Endereco  = 32'd1;
    step();
    idle();
    check("t5_valido", {31'd0, bus.busca_valido}, 32'd0);
    check("t5_carga_pronto", {31'd0, bus.carga_pronto}, 32'd1);
    check("t5_pronto", {31'd0, bus.pronto}, 32'd0);
    check("t5_estouro", {31'd0, bus.estouro}, 32'd0);
    load_word(32'h1111_0000, 1'b0);
    load_word(32'h2222_0001, 1'b1);
    fetch(32'd5, NOP, 1'b1);
    fetch(32'd1, 32'h2222_0001, 1'b0);
    fetch(32'd2, NOP, 1'b1);
    idle();
    step();

    // 6: reset in the middle of a load discards the partial program
    do_reset();
    for (int i = 0; i < 3; i++) begin
      load_word(32'hC0DE_0000 | i, 1'b0);
    end
    do_reset();
    check("t6_estouro", {31'd0, bus.estouro}, 32'd0);
    load_end();
    check("t6_pronto", {31'd0, bus.pronto}, 32'd1);
    fetch(32'd0, NOP, 1'b1);
    idle();
    step();
    step();

    // Final report
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
